fetch_queue: RTL

- Decoupling FIFO between the instruction scheduler and the core decode stage.
- Captures each valid scheduler output (pc, instruction, predicted-taken, true pc) and presents it to decode with a valid/ready handshake.
- Back-pressures the scheduler through its ce (halt) input.
- Discards all queued instructions on a misprediction redirect.

---
 rtl/fcpu_pkg.sv | 16 +
 rtl/fetch_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/fcpu_pkg.sv
// Shared fetch-path types and widths for the fcpu core.
package fcpu_pkg;

  localparam int CRAM_ADDR_W      = 15;
  localparam int DATA_W           = 32;
  localparam int FQ_DEPTH_DEFAULT = 8;

  // One scheduler beat as held in the fetch queue.
  typedef struct packed {
    logic [CRAM_ADDR_W-1:0] pc;
    logic [DATA_W-1:0]      inst;
    logic                   taken;
    logic [CRAM_ADDR_W-1:0] true_pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: ring FIFO between the instruction scheduler and decode.
// Head is presented first-word fall-through; a flush (mispredict redirect)
// empties the ring and adds the discarded occupancy to a saturating counter.
module fetch_queue
  import fcpu_pkg::*;
#(
  parameter int DEPTH     = FQ_DEPTH_DEFAULT,
  parameter int AF_MARGIN = 2,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CRAM_ADDR_W-1:0] i_pc,
  input  logic                   i_valid,
  input  logic [DATA_W-1:0]      i_inst,
  input  logic                   i_taken,
  input  logic [CRAM_ADDR_W-1:0] i_true_pc,
  output logic                   o_sched_ce,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [CRAM_ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0]      o_inst,
  output logic                   o_taken,
  output logic [CRAM_ADDR_W-1:0] o_true_pc,
  input  logic                   i_ready,
  output logic [CNT_W-1:0]       o_count,
  output logic [15:0]            o_flush_cnt
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CE_LIMIT = CNT_W'(DEPTH - AF_MARGIN);

  fq_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_ent_vld;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_flush_cnt;

  logic             w_valid;
  logic             w_ce;
  logic             w_push;
  logic             w_pop;
  logic [16:0]      w_flush_sum;
  fq_entry_t        w_in;
  fq_entry_t        w_head;

  // ce looks only at registered occupancy, so there is no loop through the scheduler.
  assign w_valid     = (r_count != '0);
  assign w_ce        = !rst && (r_count < CE_LIMIT);
  assign w_push      = i_valid && w_ce && !i_flush;
  assign w_pop       = w_valid && i_ready && !i_flush;
  assign w_flush_sum = {1'b0, r_flush_cnt} + 17'(r_count);

  assign w_in.pc      = i_pc;
  assign w_in.inst    = i_inst;
  assign w_in.taken   = i_taken;
  assign w_in.true_pc = i_true_pc;

  // Head entry, forced to zero whenever the queue is empty.
  always_comb begin
    w_head = '0;
    if (w_valid && r_ent_vld[r_head]) begin
      w_head = r_mem[r_head];
    end
  end

  // Entry payload storage; contents only matter behind a set valid bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_in;
    end
  end

  // Pointers, occupancy, entry valid bits and the flush statistic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ent_vld   <= '0;
      r_flush_cnt <= '0;
    end else if (i_flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ent_vld   <= '0;
      r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end else begin
      if (w_push) begin
        r_tail            <= r_tail + PTR_W'(1);
        r_ent_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
        if (!(w_push && (r_tail == r_head))) begin
          r_ent_vld[r_head] <= 1'b0;
        end
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_sched_ce  = w_ce;
  assign o_valid     = w_valid;
  assign o_pc        = w_head.pc;
  assign o_inst      = w_head.inst;
  assign o_taken     = w_head.taken;
  assign o_true_pc   = w_head.true_pc;
  assign o_count     = r_count;
  assign o_flush_cnt = r_flush_cnt;

endmodule
